// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART slave-port arbiter.
package uart_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMR_W  = 16;

  // Read data returned to a master whose transaction timed out.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE,
    DRAIN
  } arb_state_t;

  // Index width for n masters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr_i with wrap.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW:0] cand;

  // Scan from the farthest candidate down so the one closest to ptr_i wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IdxW + 1)'(k);
      // ptr_i < N and k < N, so one subtraction is enough to wrap.
      if (cand >= (IdxW + 1)'(N)) cand = cand - (IdxW + 1)'(N);
      if (req_i[cand[IdxW-1:0]]) idx_o = cand[IdxW-1:0];
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one UART Wishbone-style slave port between NUM_MASTERS masters.
// A grant is held until the slave acks. Optional ack timeout: define UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [ADDR_W*NUM_MASTERS-1:0]   m_addr_i,
  input  logic [DATA_W*NUM_MASTERS-1:0]   m_data_i,
  output logic [DATA_W-1:0]               m_data_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_data_o,
  input  logic [DATA_W-1:0]               s_data_i,
  input  logic                            s_ack_i,
  output logic [idx_w(NUM_MASTERS)-1:0]   grant_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int unsigned IdxW = idx_w(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("NUM_MASTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65536");
  end

  arb_state_t             state_q;
  logic [IdxW-1:0]        ptr_q;
  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;
  logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];

  assign req = m_cyc_i & m_stb_i;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr_i[ADDR_W*i +: ADDR_W];
    assign wdata_arr[i] = m_data_i[DATA_W*i +: DATA_W];
  end

  rr_picker #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q;
  logic             timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Arbiter FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_o  <= '0;
      s_cyc_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_addr_o <= '0;
      s_data_o <= '0;
      m_data_o <= '0;
      m_ack_o  <= '0;
      busy_o   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmr_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      m_ack_o <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_o  <= pick_idx;
            s_we_o   <= m_we_i[pick_idx];
            s_addr_o <= addr_arr[pick_idx];
            s_data_o <= wdata_arr[pick_idx];
            s_cyc_o  <= 1'b1;
            s_stb_o  <= 1'b1;
            busy_o   <= 1'b1;
            // The master just served gets lowest priority next time.
            ptr_q    <= (pick_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : pick_idx + IdxW'(1);
`ifdef UART_ARB_TIMEOUT_EN
            tmr_q    <= '0;
`endif
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack_i) begin
            // A master that dropped cyc has abandoned the transfer: no ack, data untouched.
            if (m_cyc_i[grant_o]) begin
              m_data_o          <= s_data_i;
              m_ack_o[grant_o]  <= 1'b1;
            end
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            state_q <= RELEASE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            if (m_cyc_i[grant_o]) begin
              m_data_o         <= TIMEOUT_DATA;
              m_ack_o[grant_o] <= 1'b1;
            end
            timeout_q <= 1'b1;
            state_q   <= DRAIN;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
`endif
        end
        RELEASE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        DRAIN: begin
          // The UART cannot abort, so keep the request up and swallow its eventual ack.
          if (s_ack_i) begin
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            state_q <= RELEASE;
          end
        end
`endif
        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomized self-checking bench for uart_bus_arbiter with a transaction-level reference model.
module tb_uart_bus_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned GW = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 65535;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [32*N-1:0] m_addr_i, m_data_i;
  logic [31:0]     m_data_o;
  logic [N-1:0]    m_ack_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]     s_addr_o, s_data_o, s_data_i;
  logic            s_ack_i;
  logic [GW-1:0]   grant_o;
  logic            busy_o, timeout_o;

  uart_bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_data_i  (m_data_i),
    .m_data_o  (m_data_o),
    .m_ack_o   (m_ack_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester scanning upward from p with wrap-around.
  function automatic int unsigned pick(input logic [N-1:0] r, input int unsigned p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Reference model: previous-cycle samples plus arbitration bookkeeping.
  bit              chk_en = 1'b0;
  logic            p_stb, p_sack;
  logic [N-1:0]    p_req, p_cyc, p_we;
  logic [32*N-1:0] p_addr, p_data;
  logic [31:0]     p_sdata, md_m, e_addr, e_data;
  logic            e_stb, e_we;
  logic [N-1:0]    e_ack;
  int unsigned     low_run, ptr_m, g_m;

  task automatic sample_inputs();
    p_stb   = s_stb_o;
    p_sack  = s_ack_i;
    p_req   = m_cyc_i & m_stb_i;
    p_cyc   = m_cyc_i;
    p_we    = m_we_i;
    p_addr  = m_addr_i;
    p_data  = m_data_i;
    p_sdata = s_data_i;
  endtask

  // A new grant needs two idle-looking cycles (RELEASE, IDLE) after the previous slave request.
  always @(negedge clk) begin
    if (chk_en) begin
      e_stb = p_stb ? !p_sack : ((low_run >= 2) && (p_req != '0));
      check_eq("s_stb", 32'(s_stb_o), 32'(e_stb));
      check_eq("s_cyc", 32'(s_cyc_o), 32'(e_stb));
      check_eq("busy", 32'(busy_o), 32'(e_stb | p_stb));
      check_eq("timeout", 32'(timeout_o), 32'd0);
      if (e_stb && !p_stb) begin
        g_m    = pick(p_req, ptr_m);
        ptr_m  = (g_m + 1) % N;
        e_we   = p_we[g_m];
        e_addr = p_addr[32*g_m +: 32];
        e_data = p_data[32*g_m +: 32];
      end
      check_eq("grant", 32'(grant_o), g_m);
      if (e_stb) begin
        check_eq("s_we", 32'(s_we_o), 32'(e_we));
        check_eq("s_addr", s_addr_o, e_addr);
        check_eq("s_data", s_data_o, e_data);
      end
      e_ack = '0;
      if (p_stb && p_sack && p_cyc[g_m]) begin
        e_ack[g_m] = 1'b1;
        md_m       = p_sdata;
      end
      check_eq("m_ack", 32'(m_ack_o), 32'(e_ack));
      check_eq("m_data", m_data_o, md_m);
      low_run = s_stb_o ? 0 : low_run + 1;
      sample_inputs();
    end
  end

  // Random master/slave behaviour, applied just after each rising edge.
  bit          auto_en  = 1'b0;
  bit          start_en = 1'b0;
  bit [N-1:0]  active   = '0;
  int unsigned gap [N];
  int unsigned sl_wait  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_en) begin
      s_ack_i = 1'b0;
      if (s_stb_o) begin
        if (sl_wait == 0) begin
          s_ack_i  = 1'b1;
          s_data_i = $urandom;
          sl_wait  = $urandom_range(0, 4);
        end else begin
          sl_wait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        s_ack_i  = 1'b1;  // stray ack, must be ignored
        s_data_i = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        if (active[i]) begin
          if (m_ack_o[i]) begin
            active[i] = 1'b0; m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0;
            gap[i] = $urandom_range(0, 3);
          end else if ($urandom_range(0, 63) == 0) begin
            active[i] = 1'b0; m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0;
            gap[i] = 12;
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if (start_en && $urandom_range(0, 2) == 0) begin
          active[i] = 1'b1; m_cyc_i[i] = 1'b1; m_stb_i[i] = 1'b1;
          m_we_i[i] = 1'($urandom);
          m_addr_i[32*i +: 32] = $urandom;
          m_data_i[32*i +: 32] = $urandom;
        end else begin
          m_cyc_i[i] = ($urandom_range(0, 7) == 0);  // cyc without stb is not a request
          m_stb_i[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_stb(input string tag);
    int unsigned n = 0;
    while (!s_stb_o && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, 32'(s_stb_o), 32'd1);
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_data_i = '0;
    s_ack_i = 1'b0; s_data_i = '0;
  endtask

  int unsigned exp_g [4] = '{0, 1, 0, 1};
  int unsigned got_g [4];
  int unsigned n_got;
  int unsigned cnt;
  logic        prev_stb;

  initial begin
    clear_inputs();
    for (int i = 0; i < N; i++) gap[i] = 0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check_eq("rst_s_stb", 32'(s_stb_o), 32'd0);
    check_eq("rst_s_we", 32'(s_we_o), 32'd0);
    check_eq("rst_s_addr", s_addr_o, 32'd0);
    check_eq("rst_s_data", s_data_o, 32'd0);
    check_eq("rst_m_data", m_data_o, 32'd0);
    check_eq("rst_m_ack", 32'(m_ack_o), 32'd0);
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    sample_inputs();
    low_run = 2; ptr_m = 0; g_m = 0; md_m = '0;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    #1 chk_en = 1'b1;

    // Master 0 writes 0x41 to 0x0, slave acks three cycles after the strobe.
    @(posedge clk); #1;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b1;
    m_addr_i[31:0] = 32'h0; m_data_i[31:0] = 32'h41;
    step();
    check_eq("wr_stb_latency", 32'(s_stb_o), 32'd1);
    check_eq("wr_s_we", 32'(s_we_o), 32'd1);
    check_eq("wr_s_addr", s_addr_o, 32'h0);
    check_eq("wr_s_data", s_data_o, 32'h41);
    step(); step(); step();
    s_ack_i = 1'b1; s_data_i = 32'h0;
    step();
    s_ack_i = 1'b0;
    check_eq("wr_ack", 32'(m_ack_o), 32'b001);
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; m_we_i[0] = 1'b0;
    step();
    check_eq("wr_ack_one_cycle", 32'(m_ack_o), 32'd0);
    step(); step();

    // Master 1 reads 0x4, slave returns 0x1.
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_addr_i[63:32] = 32'h4;
    step();
    check_eq("rd_grant", 32'(grant_o), 32'd1);
    check_eq("rd_s_addr", s_addr_o, 32'h4);
    s_ack_i = 1'b1; s_data_i = 32'h1;
    step();
    s_ack_i = 1'b0;
    check_eq("rd_ack", 32'(m_ack_o), 32'b010);
    check_eq("rd_data", m_data_o, 32'h1);
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    step();
    check_eq("rd_data_hold", m_data_o, 32'h1);
    step(); step();

    // Masters 0 and 1 request continuously; grants must alternate.
    m_cyc_i[1:0] = 2'b11; m_stb_i[1:0] = 2'b11;
    n_got = 0; cnt = 0; prev_stb = 1'b0;
    while (n_got < 4 && cnt < 60) begin
      step();
      cnt++;
      s_ack_i = s_stb_o;
      if (s_stb_o && !prev_stb) begin
        got_g[n_got] = 32'(grant_o);
        n_got++;
      end
      prev_stb = s_stb_o;
    end
    check_eq("alt_count", n_got, 4);
    for (int i = 0; i < 4; i++) check_eq("alt_grant", got_g[i], exp_g[i]);
    m_cyc_i = '0; m_stb_i = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      s_ack_i = s_stb_o;
    end
    s_ack_i = 1'b0;
    step(); step();

    // Master 0 abandons its transfer mid-BUSY.
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0; m_addr_i[31:0] = 32'h8;
    wait_stb("abort_stb");
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    step(); step();
    check_eq("abort_stb_held", 32'(s_stb_o), 32'd1);
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    step();
    s_ack_i = 1'b0;
    check_eq("abort_no_ack", 32'(m_ack_o), 32'd0);
    check_eq("abort_stb_drop", 32'(s_stb_o), 32'd0);
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_addr_i[63:32] = 32'hC;
    wait_stb("after_abort_stb");
    s_ack_i = 1'b1; s_data_i = 32'h77;
    step();
    s_ack_i = 1'b0;
    check_eq("after_abort_ack", 32'(m_ack_o), 32'b010);
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    step(); step();

    // Randomized traffic.
    auto_en = 1'b1; start_en = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    start_en = 1'b0;
    for (int i = 0; i < 60; i++) step();
    auto_en = 1'b0;
    active = '0;
    clear_inputs();
    step(); step(); step();

`ifdef UART_ARB_TIMEOUT_EN
    // Slave never acks: abort after TO BUSY cycles, then drain the late ack.
    chk_en = 1'b0;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0;
    wait_stb("to_stb");
    cnt = 0;
    while (m_ack_o == '0 && cnt < 100) begin
      step();
      cnt++;
    end
    check_eq("to_cycles", cnt, TO);
    check_eq("to_ack", 32'(m_ack_o), 32'b001);
    check_eq("to_data", m_data_o, 32'hFFFF_FFFF);
    check_eq("to_pulse", 32'(timeout_o), 32'd1);
    check_eq("to_stb_held", 32'(s_stb_o), 32'd1);
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    step();
    check_eq("to_pulse_end", 32'(timeout_o), 32'd0);
    check_eq("drain_stb", 32'(s_stb_o), 32'd1);
    step(); step(); step();
    s_ack_i = 1'b1; s_data_i = 32'h55;
    step();
    s_ack_i = 1'b0;
    check_eq("drain_no_ack", 32'(m_ack_o), 32'd0);
    check_eq("drain_stb_drop", 32'(s_stb_o), 32'd0);
    check_eq("drain_data_kept", m_data_o, 32'hFFFF_FFFF);
    step();
    check_eq("drain_idle", 32'(busy_o), 32'd0);
`else
    // Without the timeout, a silent slave stalls the arbiter indefinitely.
    m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_we_i[2] = 1'b0;
    wait_stb("stall_stb");
    for (int i = 0; i < 40; i++) step();
    check_eq("stall_stb_held", 32'(s_stb_o), 32'd1);
    check_eq("stall_busy", 32'(busy_o), 32'd1);
    check_eq("stall_no_ack", 32'(m_ack_o), 32'd0);
    s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
    step();
    s_ack_i = 1'b0;
    check_eq("stall_ack", 32'(m_ack_o), 32'b100);
    m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
    step(); step();
`endif

    // Asynchronous reset while BUSY drops the slave request without a clock edge.
    chk_en = 1'b0;
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
    wait_stb("rst_busy_stb");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_s_stb", 32'(s_stb_o), 32'd0);
    check_eq("arst_s_cyc", 32'(s_cyc_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_grant", 32'(grant_o), 32'd0);
    m_cyc_i = '1; m_stb_i = '1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_stb("arst_regrant_stb");
    check_eq("arst_ptr_zero", 32'(grant_o), 32'd0);
    clear_inputs();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Shares the single UART Wishbone-style slave port between NUM_MASTERS requesters (CPU data bus, debug/boot loader, DMA).
- Round-robin arbitration. A grant is held until the slave acknowledges, so each transaction is atomic.
- Sits between the interconnect and the UART peripheral. Drives the slave's cyc/stb/we/addr/data and routes ack/data back only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 65535, cycles to wait for a slave ack before aborting (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master transaction active
- m_stb_i  in  NUM_MASTERS  per-master request strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_addr_i  in  32*NUM_MASTERS  per-master address, master i at [32*i+:32]
- m_data_i  in  32*NUM_MASTERS  per-master write data
- m_data_o  out  32  read data, shared; valid only while m_ack_o[i]
- m_ack_o  out  NUM_MASTERS  one-hot, one-cycle ack pulse
- s_cyc_o  out  1  to slave cyc_i
- s_stb_o  out  1  to slave stb_i
- s_we_o  out  1  to slave we_i
- s_addr_o  out  32  to slave addr_i
- s_data_o  out  32  to slave data_i
- s_data_i  in  32  from slave data_o
- s_ack_i  in  1  from slave ack_o
- grant_o  out  $clog2(NUM_MASTERS)  index of current/last granted master
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on timeout abort; constant 0 without UART_ARB_TIMEOUT_EN

Behaviour:
- All outputs are registered. On rst, asynchronously and at once:
  - state = IDLE, rr pointer = 0, grant_o = 0.
  - s_cyc_o, s_stb_o, s_we_o = 0; s_addr_o, s_data_o, m_data_o = 0.
  - m_ack_o = 0, busy_o = 0, timeout_o = 0, timeout counter = 0.
  - Reset mid-transaction drops the slave request immediately. The slave has its own reset.
- Request: req[i] = m_cyc_i[i] & m_stb_i[i].
- States and transitions:
  - IDLE: if any req, pick the first set req[i] scanning from pointer upward with wrap-around (pointer, pointer+1, ..., NUM_MASTERS-1, 0, ...).
    - Next edge: latch i into grant_o; copy that master's we/addr/data to s_*; assert s_cyc_o and s_stb_o; pointer <= (i+1) mod NUM_MASTERS; go to BUSY.
    - Latency: 1 cycle from request to slave strobe.
  - BUSY: s_* held constant. On s_ack_i:
    - next edge: m_data_o <= s_data_i; m_ack_o[grant_o] <= 1 (one cycle); s_cyc_o, s_stb_o <= 0; go to RELEASE.
    - Ack-to-master latency: 1 cycle.
  - RELEASE: 1 cycle, then IDLE. No new grant in IDLE→BUSY→RELEASE. Lets the master drop stb and lets the slave's post-ack wait cycle elapse.
  - DRAIN (timeout build only): s_cyc_o/s_stb_o stay asserted until s_ack_i. The ack and data are discarded (no m_ack_o). Then go to RELEASE.
- Fairness: a master just served has lowest priority next arbitration. Simultaneous requests are served in rotating order. Minimum spacing between back-to-back grants is 3 cycles (BUSY ≥1, RELEASE 1, IDLE 1).
- Master aborts (drops m_cyc_i while granted): the slave request stays until s_ack_i, since the UART cannot abort. The resulting m_ack_o is suppressed if m_cyc_i[grant_o] = 0 in the ack cycle.
- s_ack_i outside BUSY/DRAIN: ignored.
- m_data_o keeps its last value between acks.
- Width rules:
  - grant_o width = max(1, $clog2(NUM_MASTERS)).
  - Pointer increment wraps mod NUM_MASTERS, including non-power-of-2 values.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack_i.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack (e.g. an RX read with an empty FIFO):
    - next edge: m_ack_o[grant_o] pulses, m_data_o = 32'hFFFF_FFFF, timeout_o pulses 1 cycle; go to DRAIN.
  - An ack arriving in the same cycle as expiry wins: normal path, no timeout.
- Undefined: no counter and no DRAIN state; BUSY waits indefinitely; timeout_o tied 0.

Decomposition:
- Package uart_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RELEASE, DRAIN}
  - localparam ADDR_W = 32, DATA_W = 32
  - TIMEOUT_DATA = 32'hFFFF_FFFF
- Sub-module rr_picker (combinational): inputs req vector and pointer; outputs valid and one index. Instantiated once.

Test Plan:
- Single master 0 write to addr 0x0 with data 0x41; slave acks 3 cycles after s_stb_o → s_stb_o 1 cycle after request; s_* = {we=1, addr=0x0, data=0x41}; m_ack_o = 2'b01 for exactly 1 cycle.
- Masters 0 and 1 request reads in the same cycle from reset → master 0 served first, then master 1. grant_o sequence 0,1. With both held continuously, grants alternate 0,1,0,1.
- Master 1 read of addr 0x4; slave returns 0x1 → m_data_o = 0x0000_0001 when m_ack_o = 2'b10. m_ack_o[0] stays 0 throughout.
- rst asserted while BUSY → s_cyc_o/s_stb_o fall without a clock edge. After release, the first request goes to master 0 (pointer = 0).
- Master 0 drops m_cyc_i mid-BUSY → s_stb_o held until s_ack_i; no m_ack_o pulse; next grant proceeds normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never acks → after 16 BUSY cycles, m_ack_o pulses with 0xFFFF_FFFF and timeout_o pulses. State is DRAIN until a later slave ack, which is swallowed; then IDLE.
